// File: rtl/tinydec.sv
`default_nettype none
// ============================================================================
// Module   : tinydec
// Purpose  : Iterative 16-bit-half TEA-style decryptor, one round per clock,
//            with a memory-mapped key/delta/round/enable register file.
// Option   : TINYDEC_CFGLOCK_EN - drop config writes while busy, flag lockerr
// Revision : 1.0 - initial release
// ============================================================================
module tinydec #(
  parameter logic [63:0] KEY   = 64'h816fc52b09e74da3,
  parameter logic [15:0] DELTA = 16'h1,
  parameter int          SHL   = 4,
  parameter int          SHR   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_k0, r_k1, r_k2, r_k3, r_delta;
  logic [2:0]  r_round;
  logic        r_enable;
  logic [15:0] r_x, r_y, r_sum;
  logic [7:0]  r_i;

  logic        w_sel0, w_sel4, w_sel8, w_selc, w_dec, w_wr, w_wr_ok, w_lockerr;
  logic        w_start, w_round, w_done;
  logic [15:0] w_y_new, w_x_new;

  function automatic logic [15:0] f_mix(input logic [15:0] v, ka, kb, s);
    logic [15:0] l_shl, l_shr;
    l_shl = v << SHL;
    l_shr = v >> SHR;
    return (l_shl + ka) ^ (v + s) ^ (l_shr + kb);
  endfunction

  assign pready = 1'b1;
  assign ack    = (r_state == S_IDLE);

  assign w_sel0 = (paddr == 32'h0000_0000);
  assign w_sel4 = (paddr == 32'h0000_0004);
  assign w_sel8 = (paddr == 32'h0000_0008);
  assign w_selc = (paddr == 32'h0000_000C);
  assign w_dec  = w_sel0 | w_sel4 | w_sel8 | w_selc;
  assign w_wr   = psel & penable & pwrite & w_dec;

`ifdef TINYDEC_CFGLOCK_EN
  logic r_lockerr;

  // Busy-time writes are discarded and remembered until software rewrites 0xC.
  assign w_wr_ok   = w_wr & ack;
  assign w_lockerr = r_lockerr;

  always_ff @(posedge clk) begin
    if (rst)
      r_lockerr <= 1'b0;
    else if (w_wr & ~ack)
      r_lockerr <= 1'b1;
    else if (w_wr_ok & w_selc)
      r_lockerr <= 1'b0;
  end
`else
  assign w_wr_ok   = w_wr;
  assign w_lockerr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_k3, r_k2, r_k1, r_k0} <= KEY;
      r_delta  <= DELTA;
      r_round  <= 3'd0;
      r_enable <= 1'b1;
    end else if (w_wr_ok) begin
      if (w_sel0) {r_k1, r_k0} <= pwdata;
      if (w_sel4) {r_k3, r_k2} <= pwdata;
      if (w_sel8) r_delta <= pwdata[15:0];
      if (w_selc) begin
        r_round  <= pwdata[2:0];
        r_enable <= pwdata[3];
      end
    end
  end

  // Read data shows pre-write register contents; bits a register lacks hold.
  always_ff @(posedge clk) begin
    if (rst)
      prdata <= 32'h0;
    else if (psel) begin
      if (w_sel0) prdata <= {r_k1, r_k0};
      if (w_sel4) prdata <= {r_k3, r_k2};
      if (w_sel8) prdata[15:0] <= r_delta;
      if (w_selc) prdata[4:0] <= {w_lockerr, r_enable, r_round};
    end
  end

  assign w_start = (r_state == S_IDLE) & r_enable & req;
  assign w_round = (r_state == S_RUN) & r_enable;
  assign w_done  = w_round & (r_i == 8'd1);
  assign w_y_new = r_y - f_mix(r_x, r_k2, r_k3, r_sum);
  assign w_x_new = r_x - f_mix(w_y_new, r_k0, r_k1, r_sum);

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_RUN;
      S_RUN:  if (!r_enable || w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= 16'h0;
      r_y   <= 16'h0;
      r_sum <= 16'h0;
      r_i   <= 8'h0;
      rdata <= 32'h0;
    end else if (w_start) begin
      r_x   <= wdata[15:0];
      r_y   <= wdata[31:16];
      r_sum <= r_delta << r_round;
      r_i   <= 8'd1 << r_round;
    end else if (w_round) begin
      r_y   <= w_y_new;
      r_x   <= w_x_new;
      r_sum <= r_sum - r_delta;
      r_i   <= r_i - 8'd1;
      if (w_done) rdata <= {w_y_new, w_x_new};
    end
  end

endmodule
`default_nettype wire

// File: doc/tinydec.md
TINYDEC -- requirements
Module: tinydec

Interface
REQ-001 Parameter KEY, default 64'h816fc52b09e74da3, reset value of {k3,k2,k1,k0} (16 bits each).
REQ-002 Parameter DELTA, default 16'h1, reset value of delta.
REQ-003 Parameter SHL, default 4, left shift amount in round function.
REQ-004 Parameter SHR, default 5, right shift amount in round function.
REQ-005 clk  input  1  sole clock; all logic, including config, on posedge clk.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req  input  1  decrypt request, sampled while ack=1.
REQ-008 wdata  input  32  ciphertext; [15:0]=x, [31:16]=y.
REQ-009 ack  output  1  high when idle, ready for req.
REQ-010 rdata  output  32  plaintext; [15:0]=x, [31:16]=y.
REQ-011 psel, penable, pwrite  input  1 each  config bus controls.
REQ-012 paddr  input  32  config address; pwdata  input  32  write data.
REQ-013 prdata  output  32  config read data, registered; pready  output  1  tied 1.

Function
REQ-014 Registers: 0x0 {k1,k0}; 0x4 {k3,k2}; 0x8 delta in [15:0]; 0xC round in [2:0], enable in [3]; other addresses: no effect, prdata holds.
REQ-015 When psel=1 and paddr decodes, prdata loads the register next edge (unused bits hold); write occurs when psel&penable&pwrite.
REQ-016 Round count N = 1<<round (1..128); initial sum = (delta<<round) truncated to 16 bits.
REQ-017 States IDLE (ack=1) and RUN (ack=0), with counter i[7:0].
REQ-018 IDLE, req=1, enable=1 at edge: x<=wdata[15:0], y<=wdata[31:16], sum<=initial sum, i<=N, enter RUN.
REQ-019 RUN per edge, in order: y -= ((x<<SHL)+k2)^(x+sum)^((x>>SHR)+k3); then x -= ((y_new<<SHL)+k0)^(y_new+sum)^((y_new>>SHR)+k1); then sum -= delta; i -= 1; all 16-bit modulo.
REQ-020 At the RUN edge where i==1: rdata<={y,x} (post-round values), enter IDLE; ack low exactly N cycles.
REQ-021 For identical k0..k3, delta, round, tinydec output equals the plaintext that tinyenc encrypted.
REQ-022 enable=0: core forced to IDLE next edge, any in-flight operation aborted, rdata unchanged, req ignored.
REQ-023 req while ack=0 is ignored; req held high re-triggers on each IDLE edge.
REQ-024 Config writes during RUN take effect on the next round edge (no snapshot) unless REQ-028 applies.

Reset
REQ-025 rst=1 at edge: state IDLE, i=0, ack=1, rdata=0, prdata=0, x=y=sum=0.
REQ-026 rst=1 at edge: {k3,k2,k1,k0}=KEY, delta=DELTA, round=0, enable=1; rst overrides req and bus writes, aborting RUN.

Configuration
REQ-027 Macro TINYDEC_CFGLOCK_EN selects config write locking.
REQ-028 Defined: writes to 0x0-0xC while ack=0 are dropped and set sticky lockerr, read at 0xC bit[4], cleared by any accepted write to 0xC; writes with ack=1 behave per REQ-015.
REQ-029 Undefined: no locking, 0xC bit[4] reads 0, REQ-024 applies.

Verification
REQ-030 Reset, keys 0, delta 0, round 0, req with wdata 0 -> ack low 1 cycle, rdata=0x00000000.
REQ-031 delta=0x9E37, round=7 written, req -> first RUN sum=0x1B80, ack low 128 cycles.
REQ-032 Default KEY/DELTA, round=5: tinyenc encrypts 0x12345678, ciphertext into tinydec -> rdata=0x12345678 after 32 cycles.
REQ-033 Write enable=0 mid-RUN -> ack=1 next edge, rdata unchanged; rewrite enable=1, req -> normal completion.
REQ-034 rst pulsed mid-RUN -> ack=1, rdata=0, keys=KEY, round=0 after the edge.
REQ-035 TINYDEC_CFGLOCK_EN defined: write 0x0 during RUN -> keys unchanged, 0xC bit[4]=1; write 0xC when idle -> bit[4]=0.
